// File: rtl/atm_keypad_entry.sv
// Keypad front end: assembles a decimal account number and a one-digit PIN from key strobes.
// Latency: one cycle from the sampling clock edge to every registered output.
// Backpressure: none on keys; credentials are held on cred_valid until cred_ack, cancel or session_exit.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   key_valid      one-cycle strobe qualifying key_code
//   key_code       0-9 digit, A=ENTER, B=CLEAR, C=CANCEL, D-F ignored
//   cred_ack       controller consumed the credentials (acted on in DONE only)
//   session_exit   controller exit, returns to IDLE from any state
//   acc_number     binary account number, valid while cred_valid
//   pin            binary PIN digit, valid while cred_valid
//   cred_valid     level, credentials stable and ready
//   entry_error    one-cycle pulse, rejected key or value
//   timeout        one-cycle pulse, inactivity abort
//   busy           high in ACC, PIN or DONE
module atm_keypad_entry #(
    parameter int ACC_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        cred_ack,
    input  logic        session_exit,
    output logic [11:0] acc_number,
    output logic [3:0]  pin,
    output logic        cred_valid,
    output logic        entry_error,
    output logic        timeout,
    output logic        busy
);

    localparam int DW = $clog2(ACC_DIGITS + 1);
    localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [3:0]    KEY_ENTER  = 4'hA;
    localparam logic [3:0]    KEY_CLEAR  = 4'hB;
    localparam logic [3:0]    KEY_CANCEL = 4'hC;
    localparam logic [DW-1:0] DIG_FULL   = DW'(ACC_DIGITS);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_PIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [13:0]   acc_acc_q, acc_acc_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [3:0]    pin_acc_q, pin_acc_d;
    logic          pin_have_q, pin_have_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [11:0]   acc_number_q, acc_number_d;
    logic [3:0]    pin_q, pin_d;
    logic          cred_valid_q, cred_valid_d;
    logic          entry_error_q, entry_error_d;
    logic          timeout_q, timeout_d;

    logic key_digit, key_enter, key_clear, key_cancel, key_live;
    logic entering;
    logic clear_all;

    always_comb begin
        key_digit  = key_valid && (key_code <= 4'd9);
        key_enter  = key_valid && (key_code == KEY_ENTER);
        key_clear  = key_valid && (key_code == KEY_CLEAR);
        key_cancel = key_valid && (key_code == KEY_CANCEL);
        // D-F are not "live": they neither act nor count as activity.
        key_live   = key_digit || key_enter || key_clear || key_cancel;
        entering   = (state_q == ST_ACC) || (state_q == ST_PIN);
    end

    always_comb begin
        state_d       = state_q;
        acc_acc_d     = acc_acc_q;
        dcnt_d        = dcnt_q;
        pin_acc_d     = pin_acc_q;
        pin_have_d    = pin_have_q;
        acc_number_d  = acc_number_q;
        pin_d         = pin_q;
        cred_valid_d  = cred_valid_q;
        entry_error_d = 1'b0;
        timeout_d     = 1'b0;
        clear_all     = 1'b0;
        idle_cnt_d    = '0;

        if (entering) begin
            idle_cnt_d = key_live ? '0 : idle_cnt_q + 1'b1;
        end

        // Exit, ack and timeout all outrank a coincident key, which is dropped.
        if (session_exit) begin
            state_d   = ST_IDLE;
            clear_all = 1'b1;
        end else if ((state_q == ST_DONE) && cred_ack) begin
            state_d   = ST_IDLE;
            clear_all = 1'b1;
        end else if (entering && (idle_cnt_q == IDLE_LAST)) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
            clear_all = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (key_digit) begin
                        acc_acc_d  = {10'd0, key_code};
                        dcnt_d     = DW'(1);
                        idle_cnt_d = '0;
                        state_d    = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (key_digit) begin
                        if (dcnt_q < DIG_FULL) begin
                            // At most ACC_DIGITS-1 digits held here, so *10+9 stays within 14 bits.
                            acc_acc_d = 14'(acc_acc_q * 14'd10 + {10'd0, key_code});
                            dcnt_d    = dcnt_q + 1'b1;
                        end else begin
                            entry_error_d = 1'b1;
                        end
                    end else if (key_enter) begin
                        if ((dcnt_q == DIG_FULL) && (acc_acc_q <= 14'd4095)) begin
                            acc_number_d = acc_acc_q[11:0];
                            pin_have_d   = 1'b0;
                            state_d      = ST_PIN;
                        end else begin
                            entry_error_d = 1'b1;
                            acc_acc_d     = '0;
                            dcnt_d        = '0;
                        end
                    end else if (key_clear) begin
                        acc_acc_d = '0;
                        dcnt_d    = '0;
                    end else if (key_cancel) begin
                        acc_acc_d = '0;
                        dcnt_d    = '0;
                        state_d   = ST_IDLE;
                    end
                end
                ST_PIN: begin
                    if (key_digit) begin
                        if (!pin_have_q) begin
                            pin_acc_d  = key_code;
                            pin_have_d = 1'b1;
                        end else begin
                            entry_error_d = 1'b1;
                        end
                    end else if (key_enter) begin
                        if (pin_have_q) begin
                            pin_d        = pin_acc_q;
                            cred_valid_d = 1'b1;
                            state_d      = ST_DONE;
                        end else begin
                            entry_error_d = 1'b1;
                        end
                    end else if (key_clear) begin
                        pin_have_d = 1'b0;
                    end else if (key_cancel) begin
                        state_d   = ST_IDLE;
                        clear_all = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (key_cancel) begin
                        state_d   = ST_IDLE;
                        clear_all = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    clear_all = 1'b1;
                end
            endcase
        end

        if (clear_all) begin
            acc_acc_d    = '0;
            dcnt_d       = '0;
            pin_acc_d    = '0;
            pin_have_d   = 1'b0;
            acc_number_d = '0;
            pin_d        = '0;
            cred_valid_d = 1'b0;
            idle_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            acc_acc_q     <= '0;
            dcnt_q        <= '0;
            pin_acc_q     <= '0;
            pin_have_q    <= 1'b0;
            idle_cnt_q    <= '0;
            acc_number_q  <= '0;
            pin_q         <= '0;
            cred_valid_q  <= 1'b0;
            entry_error_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_acc_q     <= acc_acc_d;
            dcnt_q        <= dcnt_d;
            pin_acc_q     <= pin_acc_d;
            pin_have_q    <= pin_have_d;
            idle_cnt_q    <= idle_cnt_d;
            acc_number_q  <= acc_number_d;
            pin_q         <= pin_d;
            cred_valid_q  <= cred_valid_d;
            entry_error_q <= entry_error_d;
            timeout_q     <= timeout_d;
        end
    end

    assign acc_number  = acc_number_q;
    assign pin         = pin_q;
    assign cred_valid  = cred_valid_q;
    assign entry_error = entry_error_q;
    assign timeout     = timeout_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry with a short inactivity limit.
// Keys are driven on the falling edge and outputs are checked on the falling edge.
// Expected values are hand-computed constants per step.
module tb_atm_keypad_entry;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        cred_ack;
    logic        session_exit;
    logic [11:0] acc_number;
    logic [3:0]  pin;
    logic        cred_valid;
    logic        entry_error;
    logic        timeout;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    atm_keypad_entry #(
        .ACC_DIGITS     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .cred_ack     (cred_ack),
        .session_exit (session_exit),
        .acc_number   (acc_number),
        .pin          (pin),
        .cred_valid   (cred_valid),
        .entry_error  (entry_error),
        .timeout      (timeout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the key is sampled on the next rising edge
    // and the call returns on the falling edge where its effect is visible.
    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic pulse_ack();
        cred_ack = 1'b1;
        @(negedge clk);
        cred_ack = 1'b0;
    endtask

    task automatic pulse_exit();
        session_exit = 1'b1;
        @(negedge clk);
        session_exit = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        key_valid    = 1'b0;
        key_code     = 4'h0;
        cred_ack     = 1'b0;
        session_exit = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_acc",   32'(acc_number), 32'd0);
        chk("rst_pin",   32'(pin),        32'd0);
        chk("rst_cv",    32'(cred_valid), 32'd0);
        chk("rst_err",   32'(entry_error),32'd0);
        chk("rst_to",    32'(timeout),    32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: 1234 / 6, held without ack, then acknowledged
        press(4'h1);
        chk("t1_busy_first", 32'(busy), 32'd1);
        press(4'h2); press(4'h3); press(4'h4);
        press(4'hA);
        chk("t1_enter_noerr", 32'(entry_error), 32'd0);
        chk("t1_pin_state_cv", 32'(cred_valid), 32'd0);
        press(4'h6);
        press(4'hA);
        chk("t1_cv",  32'(cred_valid), 32'd1);
        chk("t1_acc", 32'(acc_number), 32'd1234);
        chk("t1_pin", 32'(pin),        32'd6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_hold_cv",  32'(cred_valid), 32'd1);
            chk("t1_hold_acc", 32'(acc_number), 32'd1234);
        end
        pulse_ack();
        chk("t1_ack_cv",   32'(cred_valid), 32'd0);
        chk("t1_ack_busy", 32'(busy),       32'd0);
        chk("t1_ack_acc",  32'(acc_number), 32'd0);
        chk("t1_ack_pin",  32'(pin),        32'd0);

        // T2: out-of-range value, then too few digits
        press(4'h6); press(4'h7); press(4'h5); press(4'h4);
        press(4'hA);
        chk("t2_range_err",  32'(entry_error), 32'd1);
        chk("t2_range_busy", 32'(busy),        32'd1);
        @(negedge clk);
        chk("t2_err_pulse",  32'(entry_error), 32'd0);
        press(4'h7); press(4'h8); press(4'h9);
        chk("t2_digit_noerr", 32'(entry_error), 32'd0);
        press(4'hA);
        chk("t2_short_err",  32'(entry_error), 32'd1);
        chk("t2_short_acc",  32'(acc_number),  32'd0);
        press(4'hC);
        chk("t2_cancel_busy", 32'(busy), 32'd0);

        // T3: clear in ACC, extra digit, clear in PIN
        press(4'h1); press(4'h2); press(4'hB);
        press(4'h3); press(4'h4); press(4'h5); press(4'h6);
        press(4'h5);
        chk("t3_extra_err", 32'(entry_error), 32'd1);
        press(4'hA);
        chk("t3_enter_noerr", 32'(entry_error), 32'd0);
        chk("t3_acc_latched", 32'(acc_number),  32'd3456);
        press(4'h0); press(4'hB); press(4'h9);
        chk("t3_pin_noerr", 32'(entry_error), 32'd0);
        press(4'hA);
        chk("t3_cv",  32'(cred_valid), 32'd1);
        chk("t3_acc", 32'(acc_number), 32'd3456);
        chk("t3_pin", 32'(pin),        32'd9);
        press(4'h5);
        chk("t3_done_key_ignored", 32'(cred_valid), 32'd1);
        press(4'hC);
        chk("t3_cancel_cv",  32'(cred_valid), 32'd0);
        chk("t3_cancel_acc", 32'(acc_number), 32'd0);
        chk("t3_cancel_busy",32'(busy),       32'd0);

        // T4: inactivity abort after 16 idle edges; a D key is not activity
        press(4'h1);
        for (int k = 1; k <= 15; k++) begin
            if (k == 5) begin
                key_valid = 1'b1;
                key_code  = 4'hD;
            end
            @(negedge clk);
            key_valid = 1'b0;
            key_code  = 4'h0;
            chk("t4_no_to_yet", 32'(timeout),     32'd0);
            chk("t4_no_err",    32'(entry_error), 32'd0);
        end
        chk("t4_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t4_to_pulse", 32'(timeout), 32'd1);
        chk("t4_to_busy",  32'(busy),    32'd0);
        @(negedge clk);
        chk("t4_to_clear", 32'(timeout), 32'd0);

        press(4'h1);
        repeat (13) @(negedge clk);
        press(4'h2);
        chk("t4_restart_no_to", 32'(timeout), 32'd0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("t4_restart_hold", 32'(timeout), 32'd0);
        end
        chk("t4_restart_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t4_restart_to", 32'(timeout), 32'd1);
        chk("t4_restart_idle", 32'(busy),  32'd0);
        @(negedge clk);

        // T5: ack + exit + cancel together in DONE; exit from PIN
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        press(4'hA); press(4'h6); press(4'hA);
        chk("t5_done_cv", 32'(cred_valid), 32'd1);
        cred_ack     = 1'b1;
        session_exit = 1'b1;
        press(4'hC);
        cred_ack     = 1'b0;
        session_exit = 1'b0;
        chk("t5_busy", 32'(busy),        32'd0);
        chk("t5_err",  32'(entry_error), 32'd0);
        chk("t5_to",   32'(timeout),     32'd0);
        chk("t5_cv",   32'(cred_valid),  32'd0);
        chk("t5_acc",  32'(acc_number),  32'd0);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
        chk("t5_pin_acc", 32'(acc_number), 32'd1234);
        pulse_exit();
        chk("t5_exit_acc",  32'(acc_number),  32'd0);
        chk("t5_exit_busy", 32'(busy),        32'd0);
        chk("t5_exit_err",  32'(entry_error), 32'd0);

        // T6: asynchronous reset mid-entry, then maximum account number
        press(4'h1); press(4'h2);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy", 32'(busy),       32'd0);
        chk("t6_async_acc",  32'(acc_number), 32'd0);
        chk("t6_async_cv",   32'(cred_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        press(4'h4); press(4'h0); press(4'h9); press(4'h5);
        press(4'hA);
        chk("t6_enter_noerr", 32'(entry_error), 32'd0);
        press(4'hA);
        chk("t6_pin_empty_err", 32'(entry_error), 32'd1);
        press(4'h1);
        press(4'h2);
        chk("t6_pin_second_err", 32'(entry_error), 32'd1);
        press(4'hA);
        chk("t6_cv",  32'(cred_valid), 32'd1);
        chk("t6_acc", 32'(acc_number), 32'd4095);
        chk("t6_pin", 32'(pin),        32'd1);
        pulse_ack();
        chk("t6_ack_cv", 32'(cred_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
